// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: opcodes, ALU codes,
// FSM states, and the instruction classifier used by the control and ALU decode.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  typedef struct packed {
    logic is_r;
    logic is_i;
    logic is_lw;
    logic is_sw;
    logic is_beq;
  } decode_t;

  // All-zero result means illegal; funct3=011 (sltu/sltiu) is treated as illegal.
  function automatic decode_t classify(input logic [31:0] instr);
    decode_t    d;
    logic [6:0] op;
    logic [2:0] f3;
    op = instr[6:0];
    f3 = instr[14:12];
    d.is_r   = (op == OP_R)   && (f3 != 3'b011);
    d.is_i   = (op == OP_I)   && (f3 != 3'b011);
    d.is_lw  = (op == OP_LW)  && (f3 == 3'b010);
    d.is_sw  = (op == OP_SW)  && (f3 == 3'b010);
    d.is_beq = (op == OP_BEQ) && (f3 == 3'b000);
    return d;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle: instruction and status in, datapath controls out.
// master = control unit, slave = datapath/memory side.
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        Zero;
  logic        memReady;
  logic        PCSrc;
  logic        ALUSrc;
  logic        RegWrite;
  logic        MemToReg;
  logic [3:0]  ALUCtrl;
  logic        loadPC;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  state;

  modport master (
    input  instr, Zero, memReady,
    output PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC, MemRead, MemWrite, state
  );

  modport slave (
    output instr, Zero, memReady,
    input  PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC, MemRead, MemWrite, state
  );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational instr -> ALUCtrl map; zero latency, no flow control.
module multicycle_ctrl_alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [3:0]  alu_ctrl_o
);

  decode_t    dec;
  logic [2:0] f3;

  assign dec = classify(instr_i);
  assign f3  = instr_i[14:12];

  // instr[30] selects SUB only for R-type; immediates may have bit 30 set.
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    if (dec.is_r || dec.is_i) begin
      case (f3)
        3'b000:  alu_ctrl_o = (dec.is_r && instr_i[30]) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_ctrl_o = ALU_SLL;
        3'b010:  alu_ctrl_o = ALU_SLT;
        3'b100:  alu_ctrl_o = ALU_XOR;
        3'b101:  alu_ctrl_o = instr_i[30] ? ALU_SRA : ALU_SRL;
        3'b110:  alu_ctrl_o = ALU_OR;
        3'b111:  alu_ctrl_o = ALU_AND;
        default: alu_ctrl_o = ALU_ADD;
      endcase
    end else if (dec.is_beq) begin
      alu_ctrl_o = ALU_SUB;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control: IF/ID/EX/[MEM]/WB sequencing, 4 cycles (5+N for LW/SW).
// Stalls in MEM until memReady; all outputs combinational from state and instr.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input logic                clk,
  input logic                rst,
  multicycle_ctrl_if.master  bus
);

  state_t     state_q, state_d;
  decode_t    dec;
  logic [3:0] alu_ctrl;

  assign dec = classify(bus.instr);

  multicycle_ctrl_alu_decoder u_alu_dec (
    .instr_i    (bus.instr),
    .alu_ctrl_o (alu_ctrl)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  assign bus.state = state_q;

  always_comb begin
    state_d      = state_q;
    bus.PCSrc    = 1'b0;
    bus.ALUSrc   = 1'b0;
    bus.RegWrite = 1'b0;
    bus.MemToReg = 1'b0;
    bus.ALUCtrl  = ALU_ADD;
    bus.loadPC   = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;

    // instr is only trusted once the fetch cycle is over.
    if (state_q != S_IF) begin
      bus.ALUSrc   = dec.is_i | dec.is_lw | dec.is_sw;
      bus.MemToReg = dec.is_lw;
      bus.ALUCtrl  = alu_ctrl;
    end

    case (state_q)
      S_IF:  state_d = S_ID;
      S_ID:  state_d = S_EX;
      S_EX:  state_d = (dec.is_lw || dec.is_sw) ? S_MEM : S_WB;
      S_MEM: begin
        bus.MemRead  = dec.is_lw;
        bus.MemWrite = dec.is_sw;
        if (bus.memReady) state_d = S_WB;
      end
      S_WB: begin
        bus.loadPC   = 1'b1;
        bus.RegWrite = dec.is_r | dec.is_i | dec.is_lw;
        bus.PCSrc    = dec.is_beq & bus.Zero;
        state_d      = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

endmodule
